// File: rtl/mode_key_debounce_if.sv
// Key/strobe bundle between the mode push-button debouncer and its consumer.
interface mode_key_debounce_if;
  logic KEY_IN;     // raw bouncing button, 1 = pressed
  logic SW_MODE;    // one-cycle pulse per accepted press
  logic KEY_LONG;   // one-cycle pulse when a press has lasted long enough
  logic KEY_LEVEL;  // debounced key level

  modport master (output KEY_IN, input SW_MODE, KEY_LONG, KEY_LEVEL);
  modport slave  (input KEY_IN, output SW_MODE, KEY_LONG, KEY_LEVEL);
endinterface

// File: rtl/mode_key_debounce.sv
// Mode push-button debouncer: two-flop synchronizer, press/release debounce
// FSM, press strobe (SW_MODE), long-press strobe (KEY_LONG) and level.
module mode_key_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter int unsigned LONG_CNT     = 4000,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clock,
  input logic               reset,   // async, active low
  mode_key_debounce_if.slave key_if
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_e;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);

  state_e             state_q, state_d;
  logic               sync1_q, key_s_q;
  logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               sw_mode_q, sw_mode_d;
  logic               key_long_q, key_long_d;
  logic               key_level_q, key_level_d;

  // Two-flop synchronizer; key_s_q is the only view of KEY_IN used below.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      key_s_q <= 1'b0;
    end else begin
      sync1_q <= key_if.KEY_IN;
      key_s_q <= sync1_q;
    end
  end

  // Next state, counters and output strobes. Counters reset to 0 on every
  // entry so they never wrap; hold_cnt saturates at LONG_CNT.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    sw_mode_d  = 1'b0;
    key_long_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end
      PRESS_DB: begin
        if (!key_s_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = '0;
          hold_cnt_d = '0;
          sw_mode_d  = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Every HELD cycle counts toward the long press, including the one
        // in which the key is first seen low.
        if (hold_cnt_q != LONG_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          key_long_d = (hold_cnt_q == LONG_LAST);
        end
        if (!key_s_q) begin
          state_d  = RELEASE_DB;
          db_cnt_d = '0;
        end
      end
      RELEASE_DB: begin
        // hold_cnt stays frozen here; a bounce back resumes it.
        if (key_s_q) begin
          state_d = HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        db_cnt_d   = '0;
        hold_cnt_d = '0;
      end
    endcase
    key_level_d = (state_d == HELD) || (state_d == RELEASE_DB);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      sw_mode_q   <= 1'b0;
      key_long_q  <= 1'b0;
      key_level_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      sw_mode_q   <= sw_mode_d;
      key_long_q  <= key_long_d;
      key_level_q <= key_level_d;
    end
  end

  assign key_if.SW_MODE   = sw_mode_q;
  assign key_if.KEY_LONG  = key_long_q;
  assign key_if.KEY_LEVEL = key_level_q;

endmodule
